// File: rtl/path_reporter.sv
// Captures the maze solver's popped result stack into a RAM, then replays it
// start-to-destination as a valid/ready stream tagged with move directions.
module path_reporter #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic       pop,
  input  logic [7:0] loc,
  input  logic       empStck,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_loc,
  output logic [1:0] out_dir,
  output logic       out_first,
  output logic       out_last,
  output logic       busy,
  output logic       report_done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, COLLECT, LOAD, EMIT, FIN} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t         state;
  logic [AW:0]    cnt;
  logic [AW-1:0]  rd_ptr;
  logic [7:0]     prev_loc;
  logic [7:0]     rd_data;
  logic           err_reg;
  logic [7:0]     mem [DEPTH];

  logic           wr_en;
  logic           is_first;
  logic           is_last;
  logic           step_bad;
  logic [1:0]     step_dir;
  logic [3:0]     row_c, col_c, row_p, col_p;

  assign wr_en = (state == COLLECT) && pop && (cnt != FULL);

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= loc;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) rd_data <= mem[rd_ptr];
  end

  assign is_first = ({1'b0, rd_ptr} == (cnt - ONE));
  assign is_last  = (rd_ptr == '0);

  assign row_c = rd_data[7:4];
  assign col_c = rd_data[3:0];
  assign row_p = prev_loc[7:4];
  assign col_p = prev_loc[3:0];

  // 5-bit compares so a 15->0 wrap is not mistaken for an adjacent step.
  always_comb begin
    step_dir = 2'd0;
    step_bad = 1'b0;
    if (!is_first) begin
      if (row_c == row_p && {1'b0, col_c} == {1'b0, col_p} + 5'd1)
        step_dir = 2'd0;
      else if (col_c == col_p && {1'b0, row_c} == {1'b0, row_p} + 5'd1)
        step_dir = 2'd1;
      else if (row_c == row_p && {1'b0, col_c} + 5'd1 == {1'b0, col_p})
        step_dir = 2'd2;
      else if (col_c == col_p && {1'b0, row_c} + 5'd1 == {1'b0, row_p})
        step_dir = 2'd3;
      else
        step_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      prev_loc <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            state   <= COLLECT;
            cnt     <= '0;
            err_reg <= 1'b0;
          end
        end
        COLLECT: begin
          if (pop) begin
            if (cnt == FULL) err_reg <= 1'b1;
            else             cnt     <= cnt + ONE;
          end else if (empStck) begin
            if (cnt == '0) begin
              state <= FIN;
            end else begin
              state  <= LOAD;
              rd_ptr <= cnt[AW-1:0] - 1'b1;
            end
          end
        end
        LOAD: state <= EMIT;
        EMIT: begin
          if (step_bad) err_reg <= 1'b1;
          if (out_ready) begin
            prev_loc <= rd_data;
            if (is_last) begin
              state <= FIN;
            end else begin
              rd_ptr <= rd_ptr - 1'b1;
              state  <= LOAD;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign out_valid   = (state == EMIT);
  assign out_loc     = out_valid ? rd_data : 8'h00;
  assign out_dir     = out_valid ? step_dir : 2'd0;
  assign out_first   = out_valid && is_first;
  assign out_last    = out_valid && is_last;
  assign busy        = (state != IDLE);
  assign report_done = (state == FIN);
  assign err         = err_reg || (out_valid && step_bad);

endmodule

// File: tb/tb_path_reporter.sv
// Directed, table-driven bench for path_reporter (built with DEPTH=4 so the
// overflow boundary is reachable with a handful of pops).
module tb_path_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic       done, pop, empStck, out_ready;
  logic [7:0] loc;
  logic       out_valid, out_first, out_last, busy, report_done, err;
  logic [7:0] out_loc;
  logic [1:0] out_dir;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  path_reporter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .done(done), .pop(pop), .loc(loc),
    .empStck(empStck), .out_ready(out_ready), .out_valid(out_valid),
    .out_loc(out_loc), .out_dir(out_dir), .out_first(out_first),
    .out_last(out_last), .busy(busy), .report_done(report_done), .err(err)
  );

  typedef struct {
    int              npops;
    logic [0:4][7:0] pops;
    int              nbeats;
    logic [0:3][7:0] bloc;
    logic [0:3][1:0] bdir;
    int              stall;
    logic            err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int beats = 0;
    int stalls = 0;
    int cyc = 0;
    bit rd_seen = 0;
    logic [9:0] snap = '0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk($sformatf("v%0d busy_collect", i), int'(busy), 1);
    for (int p = 0; p < v.npops; p++) begin
      pop = 1'b1;
      loc = v.pops[p];
      step();
    end
    pop = 1'b0;
    empStck = 1'b1;
    step();
    empStck = 1'b0;
    out_ready = 1'b1;
    while (!rd_seen && cyc < 100) begin
      if (report_done) begin
        rd_seen = 1;
        if (v.npops == 0) chk($sformatf("v%0d zero_len_latency", i), cyc, 0);
      end else begin
        if (out_valid) begin
          if (beats == v.stall && stalls < 5) begin
            if (stalls > 0)
              chk($sformatf("v%0d stall%0d stable", i, stalls),
                  int'({out_valid, out_loc, out_dir}), int'({1'b1, snap}));
            snap = {out_loc, out_dir};
            stalls++;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
            $display("[TB] v%0d beat %0d loc=%02h dir=%0d first=%0b last=%0b err=%0b",
                     i, beats, out_loc, out_dir, out_first, out_last, err);
            if (beats < v.nbeats) begin
              chk($sformatf("v%0d b%0d loc", i, beats), int'(out_loc), int'(v.bloc[beats]));
              chk($sformatf("v%0d b%0d dir", i, beats), int'(out_dir), int'(v.bdir[beats]));
              chk($sformatf("v%0d b%0d first", i, beats), int'(out_first), int'(beats == 0));
              chk($sformatf("v%0d b%0d last", i, beats), int'(out_last),
                  int'(beats == v.nbeats - 1));
              if (beats == v.nbeats - 1)
                chk($sformatf("v%0d err_last_beat", i), int'(err), int'(v.err));
            end
            beats++;
          end
        end
        step();
        cyc++;
      end
    end
    chk($sformatf("v%0d report_done_seen", i), int'(rd_seen), 1);
    chk($sformatf("v%0d beat_count", i), beats, v.nbeats);
    if (v.stall >= 0) chk($sformatf("v%0d stall_cycles", i), stalls, 5);
    step();
    chk($sformatf("v%0d report_done_one_cycle", i), int'({report_done, busy, out_valid}), 0);
    step();
    step();
    chk($sformatf("v%0d err_sticky", i), int'(err), int'(v.err));
  endtask

  initial begin
    vecs[0] = '{npops:4, pops:{8'h03, 8'h02, 8'h01, 8'h00, 8'h00}, nbeats:4,
                bloc:{8'h00, 8'h01, 8'h02, 8'h03}, bdir:{2'd0, 2'd0, 2'd0, 2'd0},
                stall:-1, err:1'b0};
    vecs[1] = '{npops:3, pops:{8'h11, 8'h01, 8'h00, 8'h00, 8'h00}, nbeats:3,
                bloc:{8'h00, 8'h01, 8'h11, 8'h00}, bdir:{2'd0, 2'd0, 2'd1, 2'd0},
                stall:-1, err:1'b0};
    vecs[2] = '{npops:3, pops:{8'h00, 8'h10, 8'h11, 8'h00, 8'h00}, nbeats:3,
                bloc:{8'h11, 8'h10, 8'h00, 8'h00}, bdir:{2'd0, 2'd2, 2'd3, 2'd0},
                stall:-1, err:1'b0};
    vecs[3] = '{npops:3, pops:{8'h23, 8'h13, 8'h12, 8'h00, 8'h00}, nbeats:3,
                bloc:{8'h12, 8'h13, 8'h23, 8'h00}, bdir:{2'd0, 2'd0, 2'd1, 2'd0},
                stall:1, err:1'b0};
    vecs[4] = '{npops:2, pops:{8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, nbeats:2,
                bloc:{8'h00, 8'h05, 8'h00, 8'h00}, bdir:{2'd0, 2'd0, 2'd0, 2'd0},
                stall:-1, err:1'b1};
    vecs[5] = '{npops:2, pops:{8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, nbeats:2,
                bloc:{8'h00, 8'h10, 8'h00, 8'h00}, bdir:{2'd0, 2'd1, 2'd0, 2'd0},
                stall:-1, err:1'b0};
    vecs[6] = '{npops:0, pops:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nbeats:0,
                bloc:{8'h00, 8'h00, 8'h00, 8'h00}, bdir:{2'd0, 2'd0, 2'd0, 2'd0},
                stall:-1, err:1'b0};
    vecs[7] = '{npops:5, pops:{8'h03, 8'h02, 8'h01, 8'h00, 8'h07}, nbeats:4,
                bloc:{8'h00, 8'h01, 8'h02, 8'h03}, bdir:{2'd0, 2'd0, 2'd0, 2'd0},
                stall:-1, err:1'b1};
    vecs[8] = '{npops:2, pops:{8'h00, 8'h0f, 8'h00, 8'h00, 8'h00}, nbeats:2,
                bloc:{8'h0f, 8'h00, 8'h00, 8'h00}, bdir:{2'd0, 2'd0, 2'd0, 2'd0},
                stall:-1, err:1'b1};

    rst = 1'b1; done = 1'b0; pop = 1'b0; empStck = 1'b0; out_ready = 1'b1; loc = 8'h00;
    repeat (3) step();
    chk("reset_outputs",
        int'({out_valid, out_loc, out_dir, out_first, out_last, busy, report_done, err}), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(i);

    // Pop while idle must not start anything.
    pop = 1'b1; loc = 8'h77;
    step();
    pop = 1'b0;
    chk("idle_pop_ignored", int'({busy, out_valid}), 0);

    // Reset in the middle of emission, then a clean run afterwards.
    begin
      int guard = 0;
      done = 1'b1; step(); done = 1'b0;
      pop = 1'b1; loc = 8'h03; step();
      loc = 8'h02; step();
      pop = 1'b0; empStck = 1'b1; step(); empStck = 1'b0;
      while (!out_valid && guard < 20) begin
        step();
        guard++;
      end
      chk("midemit_reached", int'(out_valid), 1);
      #2 rst = 1'b1;
      step();
      chk("midemit_reset", int'({out_valid, busy, report_done}), 0);
      rst = 1'b0;
      step();
    end
    run_vec(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/path_reporter.md
Name: path_reporter

Overview:
- Downstream consumer of the maze-solver controller's result stack.
- After the solver asserts done, it captures every location popped from the stack and buffers it.
- It then replays the path in forward order (start to destination) as a valid/ready stream.
- Each beat carries the cell location and the move direction from the previous cell.

Parameters:
DEPTH, 256, buffer entries (maximum path length in cells)
AW, 8, buffer address width; DEPTH must equal 2**AW

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
done  input  1  solver found destination; starts capture
pop  input  1  stack pop strobe; loc valid this cycle
loc  input  8  popped location {row[7:4], col[3:0]}
empStck  input  1  solver stack empty
out_ready  input  1  sink accepts beat
out_valid  output  1  beat valid
out_loc  output  8  cell location of beat
out_dir  output  2  move into out_loc: 00 col+1, 01 row+1, 10 col-1, 11 row-1
out_first  output  1  beat is start cell (out_dir = 00)
out_last  output  1  beat is destination cell
busy  output  1  high in any state but IDLE
report_done  output  1  one-cycle pulse after final beat accepted, or zero-length path
err  output  1  sticky: overflow or non-adjacent step; cleared on next done or rst

Behaviour:
- Reset (asynchronous): state IDLE, cnt=0, rd_ptr=0, all outputs 0.
- Storage: synchronous-write, synchronous-read RAM of DEPTH x 8. Count register cnt is AW+1 bits.
- IDLE:
  - done=1 → COLLECT; clear cnt and err.
  - pop without prior done is ignored.
- COLLECT:
  - Each cycle with pop=1: buf[cnt] <= loc; cnt++.
  - Overflow: pop while cnt==DEPTH → write dropped, err=1, cnt unchanged.
  - pop=1 and empStck=1 in the same cycle → pop is captured; stay in COLLECT.
  - empStck=1 and pop=0:
    - cnt==0 → FIN.
    - else → LOAD with rd_ptr=cnt-1.
- Ordering: buf[0] is the destination (last pushed); buf[cnt-1] is the start. Emission runs from cnt-1 down to 0.
- LOAD (1 cycle): issue RAM read at rd_ptr → EMIT.
- EMIT:
  - out_valid=1; out_loc=RAM data.
  - out_first=1 when rd_ptr==cnt-1.
  - out_last=1 when rd_ptr==0.
  - out_dir is computed from prev_loc and out_loc:
    - same row, col+1 → 00
    - row+1, same col → 01
    - same row, col-1 → 10
    - row-1, same col → 11
    - any other delta (including 4-bit wrap 15→0) → err=1 sticky, out_dir=00.
  - First beat: out_dir=00, no check.
  - Beat held stable while out_ready=0.
  - On out_valid&&out_ready:
    - prev_loc<=out_loc.
    - Not last → rd_ptr--; LOAD.
    - Last → FIN.
  - Throughput: 1 beat per 2 cycles (LOAD bubble), which is acceptable.
- FIN: report_done=1 for one cycle → IDLE.
- done asserted in any state other than IDLE is ignored.
- pop outside COLLECT is ignored.
- Reset mid-operation: immediate return to IDLE. Buffer contents are not cleared; cnt=0 invalidates them.
- busy = (state != IDLE); it is registered-state derived, with no combinational path from inputs.

Test Plan:
- Straight path: done; pops loc 0x03,0x02,0x01,0x00; empStck → beats 0x00(first,dir 00),0x01(00),0x02(00),0x03(last,00); report_done pulse; err=0.
- L-shaped path: pops 0x11,0x01,0x00 → beats 0x00 first, 0x01 dir 00, 0x11 dir 01 last. Reversed pops 0x00,0x10,0x11 (emitted 0x11,0x10,0x00) → dirs 10, 11.
- Backpressure: out_ready held 0 for 5 cycles on beat 2 → out_loc/out_dir/out_valid stable; no beat lost or duplicated; total beats = pops.
- Non-adjacent step: pops 0x05,0x00 → second beat 0x05 with err=1; err stays 1 until next done.
- Zero length: done then empStck=1 with no pop → report_done pulses 2 cycles after done; out_valid never high.
- Overflow and reset: DEPTH=4, 5 pops → err=1, 4 beats emitted. Separately, rst asserted mid-EMIT → next cycle out_valid=0, busy=0, and a new done/collect runs cleanly.
